// File: rtl/norm_stage.sv
// FP add/sub normalization: leading-zero / carry normalize with sticky folding, zero/subnormal/overflow detect.
// Two registered stages, valid/ready on both sides; a stalled output holds its data and backpressures stage 1.
module norm_stage #(
  parameter int FRAC_W = 28,
  parameter int EXP_W  = 10,
  parameter int EMIN   = -126,
  parameter int EMAX   = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic              zero_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s_final,
  output logic [EXP_W-1:0]  exp_norm,
  output logic [FRAC_W-2:0] frac_inter_norm,
  output logic              denorm_m,
  output logic              zero_m
);

  localparam int XW = 12;
  localparam logic signed [XW-1:0] EMIN_X = XW'(EMIN);
  localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
  localparam logic signed [XW-1:0] RSAT   = XW'(FRAC_W);

  logic rdy_q;
  logic v1, v2;
  logic ld1, ld2;

  assign ld2      = ~v2 | out_ready;
  assign ld1      = rdy_q & (~v1 | ld2);
  assign in_ready = ld1;
  assign out_valid = v2;

  // ---------------- stage 1: shift decision ----------------
  logic [4:0]             lz;
  logic signed [XW-1:0]   ext, lz_x, e_lz, rdiff;
  logic                   dir_d;
  logic [4:0]             amt_d;
  logic signed [XW-1:0]   e_d;
  logic                   zero_d;

  // Lowest set bit assigns first, highest set bit wins.
  always_comb begin
    lz = 5'(FRAC_W - 1);
    for (int i = 0; i <= FRAC_W - 2; i++) begin
      if (frac_in[i]) lz = 5'(FRAC_W - 2 - i);
    end
  end

  assign ext    = {{(XW-EXP_W){exp_in[EXP_W-1]}}, exp_in};
  assign lz_x   = {{(XW-5){1'b0}}, lz};
  assign e_lz   = ext - lz_x;
  assign zero_d = zero_in | (frac_in == '0);

  always_comb begin
    dir_d = 1'b0;
    amt_d = '0;
    e_d   = ext;
    rdiff = EMIN_X - ext;
    if (frac_in[FRAC_W-1]) begin
      dir_d = 1'b1;
      amt_d = 5'd1;
      e_d   = ext + XW'(1);
    end else if (e_lz >= EMIN_X) begin
      amt_d = lz;
      e_d   = e_lz;
    end else if (ext >= EMIN_X) begin
      // Full normalization would underflow: stop at EMIN, leaving a subnormal.
      amt_d = 5'(ext - EMIN_X);
      e_d   = EMIN_X;
    end else begin
      dir_d = 1'b1;
      amt_d = (rdiff > RSAT) ? 5'(FRAC_W) : 5'(rdiff);
      e_d   = EMIN_X;
    end
  end

  logic                 s1_s, s1_dir, s1_zero;
  logic [FRAC_W-1:0]    s1_frac;
  logic [4:0]           s1_amt;
  logic signed [XW-1:0] s1_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      v1      <= 1'b0;
      s1_s    <= 1'b0;
      s1_dir  <= 1'b0;
      s1_zero <= 1'b0;
      s1_frac <= '0;
      s1_amt  <= '0;
      s1_e    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_s    <= s_in;
          s1_dir  <= dir_d;
          s1_zero <= zero_d;
          s1_frac <= frac_in;
          s1_amt  <= amt_d;
          s1_e    <= e_d;
        end
      end
    end
  end

  // ---------------- stage 2: shift and classify ----------------
  logic [2*FRAC_W-1:0] rsh;
  logic [FRAC_W-1:0]   lsh;
  logic [FRAC_W-2:0]   res;
  logic                ovf;
  logic [EXP_W-1:0]    exp_d;
  logic [FRAC_W-2:0]   frac_d;
  logic                den_d;

  // Shifted-out bits land in the low half, which collapses into sticky.
  assign rsh = {s1_frac, {FRAC_W{1'b0}}} >> s1_amt;
  assign lsh = s1_frac << s1_amt;
  assign ovf = s1_e > EMAX_X;

  always_comb begin
    res = lsh[FRAC_W-2:0];
    if (s1_dir) res = rsh[2*FRAC_W-2:FRAC_W] | {{(FRAC_W-2){1'b0}}, |rsh[FRAC_W-1:0]};
    exp_d  = s1_e[EXP_W-1:0];
    frac_d = res;
    den_d  = ~res[FRAC_W-2];
    if (s1_zero) begin
      exp_d  = '0;
      frac_d = '0;
      den_d  = 1'b0;
    end else if (ovf) begin
      exp_d  = EXP_W'(EMAX + 1);
      frac_d = '0;
      den_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2              <= 1'b0;
      s_final         <= 1'b0;
      exp_norm        <= '0;
      frac_inter_norm <= '0;
      denorm_m        <= 1'b0;
      zero_m          <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s_final         <= s1_s;
        exp_norm        <= exp_d;
        frac_inter_norm <= frac_d;
        denorm_m        <= den_d;
        zero_m          <= s1_zero;
      end
    end
  end

endmodule

// File: doc/norm_stage.md
Name: norm_stage

Overview:
- Normalization stage placed directly upstream of the rounding stage in the FP add/sub datapath.
- Takes the raw post-add magnitude (with carry bit), the unbiased exponent and the sign.
- Left- or right-normalizes the magnitude, folds all shifted-out bits into the sticky bit, and detects zero, subnormal and exponent overflow.
- Registered 2-stage pipeline with valid/ready handshake on both sides; outputs connect 1:1 to the rounding stage inputs.

Parameters:
- FRAC_W, 28, width of frac_in: bit 27 = carry, bit 26 = hidden position, bits 2:0 = G/R/S.
- EXP_W, 10, width of exp_in/exp_norm, two's complement, unbiased.
- EMIN, -126, minimum normal unbiased exponent.
- EMAX, 127, maximum normal unbiased exponent.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  stage can accept the input this cycle.
- s_in  in  1  result sign.
- exp_in  in  10  unbiased exponent of bit 26; valid range -512..511.
- frac_in  in  28  unnormalized magnitude.
- zero_in  in  1  upstream forces exact zero (e.g. x-x).
- out_valid  out  1  output bundle valid.
- out_ready  in  1  rounding stage accepts.
- s_final  out  1  registered sign.
- exp_norm  out  10  normalized unbiased exponent.
- frac_inter_norm  out  27  normalized fraction: bit 26 hidden, bits 2:0 = G/R/S.
- denorm_m  out  1  result is subnormal.
- zero_m  out  1  result is exact zero.

Behaviour:
- Reset (async, rst_n=0): both stage valid flags clear; out_valid=0; all data outputs 0. in_ready=1 one cycle after deassertion. A reset mid-operation discards in-flight data and produces no partial output.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Stage 2 loads when ~v2 | out_ready. Stage 1 loads when ~v1 | (stage 2 loads).
  - in_ready = ~v1 | (~v2 | out_ready), combinational.
  - Latency is exactly 2 cycles with no stall; full throughput is 1 result per cycle.
  - Data outputs hold stable while out_valid & ~out_ready.
  - Order is preserved; no loss and no duplication.
- Stage 1 (registered):
  - zero = zero_in | (frac_in == 0).
  - lz = leading-zero count of frac_in[26:0] (0..27).
  - ext = exp_in sign-extended to 12 bits.
  - Select shift direction/amount:
    - frac_in[27]=1: right by 1, e = ext+1.
    - ext-lz >= EMIN: left by lz, e = ext-lz.
    - ext >= EMIN: left by ext-EMIN, e = EMIN.
    - Otherwise: right by EMIN-ext, saturated at 28, e = EMIN.
  - Register sign, frac_in, direction, amount (5 bits), e, zero.
- Stage 2 (registered):
  - Right shift: OR of all bits shifted out of bit 0 is ORed into result bit 0.
  - Left shift: zeros fill from bit 0.
  - Result is the 27 LSBs of the shifted value.
  - denorm_m = ~zero & (result[26] == 0).
  - Overflow when e > EMAX: exp_norm = 128, frac_inter_norm = 0, denorm_m = 0. Rounding stage then emits ±inf.
  - Otherwise exp_norm = e[9:0].
  - Zero: zero_m=1, exp_norm=0, frac_inter_norm=0, denorm_m=0, s_final passes through.
- Arithmetic:
  - Internal exponent math is 12-bit signed.
  - exp_norm is never outside -126..128, so bias addition downstream never wraps.
- Simultaneous events:
  - Input accept and output drain in the same cycle with the pipeline full is legal and keeps throughput.
  - in_valid with in_ready=0: input is ignored, and upstream must hold it stable.

Test Plan:
- frac_in=28'h4000000, exp_in=0, no stall -> out_valid exactly 2 cycles after accept; exp_norm=0, frac_inter_norm=27'h4000000, denorm_m=0, zero_m=0.
- frac_in=28'h8000003, exp_in=5 -> exp_norm=6, frac_inter_norm=27'h4000001 (sticky set). Then frac_in=28'h0000008, exp_in=0 -> exp_norm=-23 (10'h3E9), frac_inter_norm=27'h4000000.
- frac_in=28'h4000000, exp_in=-130 -> frac_inter_norm=27'h0400000, denorm_m=1. Then exp_in=-200 -> frac_inter_norm=27'h0000001 (sticky only), denorm_m=1.
- exp_in=128, frac_in=28'h4000000 -> exp_norm=128, frac_inter_norm=0. Also zero_in=1 with s_in=1 -> zero_m=1, s_final=1, other outputs 0.
- Back-to-back stream of 6 operands with out_ready low for cycles 3-5:
  - in_ready drops while both stages are full.
  - Outputs match the golden model, in order, with no duplicate or lost result.
  - Outputs are stable during the stall.
- Assert rst_n=0 with both stages valid -> out_valid=0 immediately (asynchronous); after release the first new operand appears 2 cycles after accept.
